serial_addsub: RTL and testbench



---
 rtl/serial_addsub_pkg.sv | 23 ++
 rtl/addsub_cell.sv | 27 ++
 rtl/serial_addsub.sv | 212 +++++++++++++++++++++
 tb/tb_serial_addsub.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// -----------------------------------------------------------------------------
// serial_addsub_pkg
// Shared types and helpers for the multi-cycle adder/subtractor.
//   state_e    : FSM states IDLE / RUN / DONE
//   MODE_ADD/SUB : encoding of the mode input
//   cnt_width  : width of the chunk counter for N chunks (clog2(N), minimum 1)
// -----------------------------------------------------------------------------
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_cell.sv
// -----------------------------------------------------------------------------
// addsub_cell
// 1-bit combinational full adder / full subtractor.
//   x, y   : operand bits
//   c_in   : carry-in (add) or borrow-in (sub)
//   mode   : 0 = add, 1 = subtract
//   s      : sum / difference bit
//   c_out  : carry-out (add) or borrow-out (sub)
// -----------------------------------------------------------------------------
module addsub_cell (
  input  logic x,
  input  logic y,
  input  logic c_in,
  input  logic mode,
  output logic s,
  output logic c_out
);

  // The borrow equation is the carry equation with x inverted, so one
  // majority gate serves both modes.
  logic x_eff;

  assign x_eff = x ^ mode;
  assign s     = x ^ y ^ c_in;
  assign c_out = (x_eff & y) | (y & c_in) | (x_eff & c_in);

endmodule

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB chunk
// first, carry/borrow registered between chunks. start/ready/done handshake.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request, accepted only while ready
//   mode       : 0 = a+b+cin, 1 = a-b-cin
//   a, b, cin  : operands, captured on accept
//   ready      : high in IDLE
//   busy       : high in RUN
//   done       : one-cycle completion pulse
//   result     : sum/difference, held until the next completion
//   cout       : carry-out / borrow-out, held with result
//   ovf        : signed overflow, held with result
// Optional feature macro: SERIAL_ADDSUB_OVF_EN enables ovf; when undefined,
// ovf is tied to 0 and no MSB tracking is built.
// -----------------------------------------------------------------------------
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;      // operand A, shifted right one chunk per RUN cycle
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;  // partial result, chunks enter at the MSB end
  logic               c_q, c_d;      // carry/borrow between chunks
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;

  logic [BITS_PER_CYCLE:0]   chain;
  logic [BITS_PER_CYCLE-1:0] chunk_sum;
  logic [WIDTH-1:0]          acc_next;

  // ---------------------------------------------------------------------------
  // Chunk datapath: BITS_PER_CYCLE cells rippling LSB to MSB.
  // ---------------------------------------------------------------------------
  assign chain[0] = c_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
    addsub_cell u_cell (
      .x    (a_q[i]),
      .y    (b_q[i]),
      .c_in (chain[i]),
      .mode (mode_q),
      .s    (chunk_sum[i]),
      .c_out(chain[i+1])
    );
  end

  // After N shifts the first chunk has travelled down to bit 0.
  if (BITS_PER_CYCLE == WIDTH) begin : g_acc_single
    assign acc_next = chunk_sum;
  end else begin : g_acc_shift
    assign acc_next = {chunk_sum, acc_q[WIDTH-1:BITS_PER_CYCLE]};
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
  logic ovf_calc;

  // Operand MSBs are captured on accept because the shift registers lose them.
  always_comb begin
    if (mode_q == MODE_SUB) begin
      ovf_calc = (a_msb_q != b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
    end else begin
      ovf_calc = (a_msb_q == b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    c_d      = c_q;
    mode_d   = mode_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          mode_d  = mode;
          cnt_d   = '0;
          acc_d   = '0;
`ifdef SERIAL_ADDSUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
          state_d = RUN;
        end
      end

      RUN: begin
        a_d   = a_q >> BITS_PER_CYCLE;
        b_d   = b_q >> BITS_PER_CYCLE;
        c_d   = chain[BITS_PER_CYCLE];
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          result_d = acc_next;
          cout_d   = chain[BITS_PER_CYCLE];
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf_d    = ovf_calc;
`endif
          state_d  = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the shift registers are ordinary flops, not a memory, so they are
  // cleared by reset along with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      c_q      <= 1'b0;
      mode_q   <= MODE_ADD;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign ready  = (state_q == IDLE);
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
// Three instances (BITS_PER_CYCLE = 1, 4, 8; WIDTH = 8) sharing operands and
// reset, each with its own start. Directed cases plus random operations are
// compared against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic [2:0] start_v = '0;

  logic [2:0] ready_v, busy_v, done_v, cout_v, ovf_v;
  logic [7:0] res0, res1, res2;

  int sel = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode), .a(a), .b(b), .cin(cin),
    .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .result(res0),
    .cout(cout_v[0]), .ovf(ovf_v[0]));

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode), .a(a), .b(b), .cin(cin),
    .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .result(res1),
    .cout(cout_v[1]), .ovf(ovf_v[1]));

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode), .a(a), .b(b), .cin(cin),
    .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]), .result(res2),
    .cout(cout_v[2]), .ovf(ovf_v[2]));

  function automatic logic [7:0] cur_res();
    case (sel)
      0:       return res0;
      1:       return res1;
      default: return res2;
    endcase
  endfunction

  function automatic int chunks_of(input int s);
    case (s)
      0:       return 8;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d): got 0x%0h, expected 0x%0h", tag, sel, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for result/cout, signed
  // range test for overflow.
  task automatic model_op(input logic m, input logic [7:0] x, input logic [7:0] y,
                          input logic c, output logic [7:0] r, output logic co,
                          output logic ov);
    int ux, uy, sx, sy, ci, u, s;
    ux = x;
    uy = y;
    sx = $signed(x);
    sy = $signed(y);
    ci = c;
    if (m == 1'b0) begin
      u  = ux + uy + ci;
      s  = sx + sy + ci;
      co = (u > 255);
    end else begin
      u  = ux - uy - ci;
      s  = sx - sy - ci;
      co = (u < 0);
    end
    r  = 8'(u & 255);
`ifdef SERIAL_ADDSUB_OVF_EN
    ov = (s > 127) || (s < -128);
`else
    ov = 1'b0;
`endif
  endtask

  // One complete operation on instance `which`. With poke set, extra starts
  // carrying different operands are pulsed during RUN and during DONE.
  task automatic run_op(input int which, input logic m, input logic [7:0] x,
                        input logic [7:0] y, input logic c, input bit poke);
    logic [7:0] er;
    logic       eco, eov;
    int         edges, busy_cnt, n;
    sel = which;
    n   = chunks_of(which);
    model_op(m, x, y, c, er, eco, eov);

    @(negedge clk);
    mode = m; a = x; b = y; cin = c;
    start_v = '0;
    start_v[which] = 1'b1;
    @(posedge clk);               // accept edge
    @(negedge clk);
    start_v = '0;
    // Scramble the inputs: the DUT must work from its captured copy.
    a = ~x; b = 8'($urandom); cin = ~c; mode = ~m;

    edges = 0;
    busy_cnt = 0;
    while (!done_v[which] && edges < 64) begin
      if (busy_v[which]) busy_cnt++;
      start_v[which] = (poke && edges == 2);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start_v = '0;

    check("done_latency", edges, n);
    check("busy_cycles", busy_cnt, n);
    check("result", cur_res(), er);
    check("cout", cout_v[which], eco);
    check("ovf", ovf_v[which], eov);

    if (poke) start_v[which] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v = '0;
    check("done_one_cycle", done_v[which], 1'b0);
    check("ready_after_done", ready_v[which], 1'b1);
    check("result_held", cur_res(), er);
    if (poke) begin
      @(posedge clk);
      @(negedge clk);
      check("poke_not_accepted", {busy_v[which], ready_v[which]}, 2'b01);
    end
  endtask

  initial begin
    int dn;

    // Reset state on every instance.
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      check("rst_ready", ready_v[s], 1'b1);
      check("rst_busy", busy_v[s], 1'b0);
      check("rst_done", done_v[s], 1'b0);
      check("rst_result", cur_res(), 8'h00);
      check("rst_cout", cout_v[s], 1'b0);
      check("rst_ovf", ovf_v[s], 1'b0);
    end
    rst_n = 1'b1;

    // Directed cases, one bit per cycle.
    run_op(0, 1'b0, 8'h3C, 8'h05, 1'b0, 0);
    check("tp_add_3c_05", res0, 8'h41);
    run_op(0, 1'b1, 8'h05, 8'h07, 1'b0, 0);
    check("tp_sub_05_07", {cout_v[0], res0}, 9'h1FE);

    // Reset in the third RUN cycle: outputs clear at once, no done follows.
    sel = 0;
    @(negedge clk);
    mode = 1'b1; a = 8'h33; b = 8'h11; cin = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v = '0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_result", res0, 8'h00);
    check("abort_cout", cout_v[0], 1'b0);
    check("abort_ovf", ovf_v[0], 1'b0);
    check("abort_busy_done", {busy_v[0], done_v[0]}, 2'b00);
    check("abort_ready", ready_v[0], 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) dn++;
    end
    check("abort_no_done", dn, 0);
    run_op(0, 1'b0, 8'h01, 8'h01, 1'b0, 0);
    check("tp_add_01_01", res0, 8'h02);

    run_op(0, 1'b1, 8'h10, 8'h0F, 1'b1, 0);
    check("tp_sub_10_0f_c", {cout_v[0], res0}, 9'h000);
    run_op(0, 1'b1, 8'h80, 8'h01, 1'b0, 0);
    check("tp_sub_80_01", res0, 8'h7F);
    run_op(0, 1'b0, 8'h7F, 8'h01, 1'b0, 0);
    check("tp_add_7f_01", res0, 8'h80);
    run_op(0, 1'b0, 8'hFF, 8'h00, 1'b1, 1);
    check("tp_add_ff_00_c", {cout_v[0], res0}, 9'h100);

    // Wider chunks.
    run_op(1, 1'b0, 8'h9A, 8'h66, 1'b0, 0);
    check("tp_bpc4_add", {cout_v[1], res1}, 9'h100);
    run_op(2, 1'b1, 8'h00, 8'h01, 1'b0, 0);
    check("tp_bpc8_sub", {cout_v[2], res2}, 9'h1FF);

    // Random operations across all three instances.
    for (int i = 0; i < 36; i++) begin
      run_op(i % 3, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
